timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Parametrised successor to the lab counter + pause/resume Mealy FSM pair.
- Merges prescaler, N-bit up/down counter and control FSM into one block, all on the CLOCK_50 domain (no derived clock).
- Adds up/down mode, wrap/stop mode, synchronous clear and a synchronised, edge-detected pause/resume button.
- Sits between the board switches/keys and the BCD/7-segment display path.

Parameters:
- WIDTH, 6, counter and max-value width in bits.
- TICK_DIV, 50000000, CLOCK_50 cycles per count tick (>=2).

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- PR  input  1  pause/resume request, active-high level, asynchronous to clock.
- CLR  input  1  synchronous soft clear, active-high.
- UP_DN  input  1  direction: 1 = up, 0 = down.
- WRAP_EN  input  1  1 = wrap at terminal, 0 = stop at terminal.
- MAX_CNT  input  WIDTH  terminal/start value.
- CNT_OUT  output  WIDTH  current count.
- STATE  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- TICK  output  1  one-cycle pulse on each count tick.
- WRAP_P  output  1  one-cycle pulse on each wrap.
- DONE  output  1  high while STATE==DONE.

Behaviour:
- Reset (RST_N low, async): STATE=IDLE, CNT_OUT=0, TICK=0, WRAP_P=0, DONE=0, divider=0, sync flops=0. Release is synchronous to CLOCK_50.

PR input path:
- PR passes a 2-flop synchroniser, then a rising-edge detect, giving a one-cycle pr_evt.
- STATE changes on the 3rd rising edge after PR rises.
- Holding PR high produces exactly one event.

Divider:
- Counts 0..TICK_DIV-1 only in RUN.
- TICK=1 for the cycle in which divider==TICK_DIV-1; divider returns to 0 on the next edge.
- Held in PAUSE; cleared in IDLE and DONE.

Start (IDLE + pr_evt):
- Latch UP_DN, WRAP_EN and MAX_CNT into internal registers. Later input changes are ignored until the next start.
- Up mode: start=0, terminal=max. Down mode: start=max, terminal=0.
- CNT_OUT loads start.
- If max==0 and WRAP_EN latched 0, go directly to DONE. Otherwise go to RUN.

On TICK in RUN:
- If CNT_OUT==terminal (wrap mode only): reload start and pulse WRAP_P.
- Otherwise CNT_OUT steps +1 (up) or -1 (down).
- Stop mode: when the next value equals terminal, enter DONE on the same edge (Mealy). CNT_OUT holds terminal.
- Wrap with max==0: CNT_OUT stays 0 and WRAP_P pulses every TICK.

State transitions:
- RUN + pr_evt -> PAUSE; CNT_OUT and divider hold.
- PAUSE + pr_evt -> RUN; divider resumes from its held value.
- DONE + pr_evt -> IDLE; CNT_OUT=0.
- IDLE: CNT_OUT=0.

Priority and simultaneous events:
- CLR > terminal/DONE > pr_evt > plain tick.
- CLR in any state -> IDLE, CNT_OUT=0, divider=0; a same-cycle pr_evt is discarded.
- TICK and pr_evt in the same RUN cycle: count updates, then -> PAUSE.
- If that same tick reaches terminal in stop mode: -> DONE and pr_evt is ignored.

Arithmetic:
- Unsigned WIDTH-bit values. No overflow is possible because the count never passes the terminal.

Mid-operation reset:
- Async reset in any state returns every register to its reset value immediately.

Test Plan:
1. WIDTH=6, TICK_DIV=4, UP_DN=1, WRAP_EN=0, MAX_CNT=3; pulse PR -> RUN; TICK every 4 cycles; CNT_OUT 0,1,2,3; DONE=1 on the edge CNT_OUT becomes 3 and holds. Second PR -> IDLE with CNT_OUT=0.
2. Down mode, MAX_CNT=5, WRAP_EN=1 -> CNT_OUT 5,4,3,2,1,0,5; WRAP_P pulses once on the 0->5 reload; STATE stays RUN.
3. Pause/resume: in RUN at CNT_OUT=2 with divider=1, PR -> PAUSE. Hold 20 cycles: CNT_OUT=2, no TICK. PR -> RUN; next TICK arrives 2 cycles after resume; CNT_OUT=3.
4. PR held high 50 cycles in IDLE -> exactly one transition to RUN. PR glitch is seen only after 2 sync stages, with the state change on the 3rd edge.
5. Simultaneous events: CLR and pr_evt in the same cycle in RUN -> IDLE, CNT_OUT=0. TICK and pr_evt at CNT_OUT=2 (max 3) -> DONE with CNT_OUT=3, not PAUSE.
6. Edge cases: MAX_CNT=0 with WRAP_EN=0 -> IDLE goes directly to DONE. Assert RST_N low mid-RUN -> all outputs 0 and STATE=IDLE asynchronously. Change MAX_CNT mid-RUN -> terminal unchanged.

Source files
------------

// File: rtl/timer_ctrl.sv
// Prescaled up/down counter with pause/resume control on a single clock.
// A synchronised PR edge starts, pauses, resumes and acknowledges the count.
module timer_ctrl #(
  parameter int WIDTH    = 6,
  parameter int TICK_DIV = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             PR,
  input  logic             CLR,
  input  logic             UP_DN,
  input  logic             WRAP_EN,
  input  logic [WIDTH-1:0] MAX_CNT,
  output logic [WIDTH-1:0] CNT_OUT,
  output logic [1:0]       STATE,
  output logic             TICK,
  output logic             WRAP_P,
  output logic             DONE
);

  localparam int             DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div, div_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] max_l, start_v, term_v, step_v;
  logic             up_l, wrap_l, load, at_term, pr_evt;
  // [0] and [1] are the synchroniser stages, [2] is the edge-detect history
  logic [2:0]       pr_pipe;

  assign pr_evt  = pr_pipe[1] & ~pr_pipe[2];
  assign start_v = up_l ? '0 : max_l;
  assign term_v  = up_l ? max_l : '0;
  assign step_v  = up_l ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
  assign at_term = (cnt == term_v);

  assign TICK    = (state == S_RUN) && (div == DIV_LAST);
  assign WRAP_P  = TICK && wrap_l && at_term && !CLR;
  assign DONE    = (state == S_DONE);
  assign STATE   = state;
  assign CNT_OUT = cnt;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      pr_pipe <= '0;
      state   <= S_IDLE;
      div     <= '0;
      cnt     <= '0;
      max_l   <= '0;
      up_l    <= 1'b0;
      wrap_l  <= 1'b0;
    end else begin
      pr_pipe <= {pr_pipe[1:0], PR};
      state   <= state_n;
      div     <= div_n;
      cnt     <= cnt_n;
      if (load) begin
        max_l  <= MAX_CNT;
        up_l   <= UP_DN;
        wrap_l <= WRAP_EN;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div;
    load    = 1'b0;
    if (CLR) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      div_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = '0;
          div_n = '0;
          if (pr_evt) begin
            load    = 1'b1;
            cnt_n   = UP_DN ? '0 : MAX_CNT;
            state_n = (MAX_CNT == '0 && !WRAP_EN) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (TICK) begin
            div_n = '0;
            if (at_term && wrap_l) begin
              cnt_n = start_v;
            end else if (at_term) begin
              state_n = S_DONE;
            end else begin
              cnt_n = step_v;
              if (!wrap_l && step_v == term_v) state_n = S_DONE;
            end
          end else begin
            div_n = div + DW'(1);
          end
          // reaching the terminal swallows a coincident pause request
          if (pr_evt && state_n == S_RUN) begin
            state_n = S_PAUSE;
            if (!TICK) div_n = div;
          end
        end
        S_PAUSE: begin
          if (pr_evt) state_n = S_RUN;
        end
        S_DONE: begin
          div_n = '0;
          if (pr_evt) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
